nios_mtl_sysid_arbiter: RTL and testbench

//  Front-end controller for the system-ID slave (1-bit address, 32-bit combinational readdata).

---
 rtl/nios_mtl_sysid_arbiter.sv | 142 ++++++++++++++
 tb/tb_nios_mtl_sysid_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/nios_mtl_sysid_arbiter.sv
// nios_mtl_sysid_arbiter: checks the sysid ID and timestamp words after
// reset, then shares the sysid slave between two read-only requesters.
//
// Ports:
//   clock, reset            rising-edge clock; synchronous active-high reset
//   m0_* / m1_*             Avalon-MM read-only requester ports
//                           (address, read, waitrequest, readdata,
//                           readdatavalid)
//   s_address, s_readdata   sysid control_slave; readdata is combinational
//                           from s_address
//   check_done, check_pass  boot check finished / both words matched
//   check_err_mask          bit0 = ID mismatch, bit1 = timestamp mismatch
module nios_mtl_sysid_arbiter #(
  parameter logic [31:0] EXPECTED_ID = 32'd0,
  parameter logic [31:0] EXPECTED_TS = 32'd1459350768
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        m0_address,
  input  logic        m0_read,
  output logic        m0_waitrequest,
  output logic [31:0] m0_readdata,
  output logic        m0_readdatavalid,
  input  logic        m1_address,
  input  logic        m1_read,
  output logic        m1_waitrequest,
  output logic [31:0] m1_readdata,
  output logic        m1_readdatavalid,
  output logic        s_address,
  input  logic [31:0] s_readdata,
  output logic        check_done,
  output logic        check_pass,
  output logic [1:0]  check_err_mask
);

  typedef enum logic [1:0] {
    BOOT_ID = 2'd0,
    BOOT_TS = 2'd1,
    ARB     = 2'd2
  } state_t;

  state_t      r_state;
  logic        r_prio1;
  logic        r_rdv0;
  logic        r_rdv1;
  logic [31:0] r_rd0;
  logic [31:0] r_rd1;
  logic        r_done;
  logic        r_pass;
  logic [1:0]  r_err;

  logic        w_arb;
  logic        w_gnt0;
  logic        w_gnt1;
  logic        w_id_bad;
  logic        w_ts_bad;

  // Nothing is accepted in a reset cycle: that transfer would be dropped.
  assign w_arb = (r_state == ARB) & ~reset;

  // r_prio1 set means m1 wins a tie (m0 was granted last).
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (w_arb) begin
      if (m0_read && m1_read) begin
        w_gnt0 = ~r_prio1;
        w_gnt1 = r_prio1;
      end else begin
        w_gnt0 = m0_read;
        w_gnt1 = m1_read;
      end
    end
  end

  always_comb begin
    s_address = 1'b0;
    unique case (r_state)
      BOOT_TS: s_address = 1'b1;
      ARB: begin
        if (w_gnt0)
          s_address = m0_address;
        else if (w_gnt1)
          s_address = m1_address;
      end
      default: s_address = 1'b0;
    endcase
  end

  assign w_id_bad = (s_readdata != EXPECTED_ID);
  assign w_ts_bad = (s_readdata != EXPECTED_TS);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= BOOT_ID;
      r_prio1 <= 1'b0;
      r_rdv0  <= 1'b0;
      r_rdv1  <= 1'b0;
      r_rd0   <= 32'd0;
      r_rd1   <= 32'd0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
      r_err   <= 2'b00;
    end else begin
      r_rdv0 <= w_gnt0;
      r_rdv1 <= w_gnt1;
      if (w_gnt0)
        r_rd0 <= s_readdata;
      if (w_gnt1)
        r_rd1 <= s_readdata;
      if (w_gnt0)
        r_prio1 <= 1'b1;
      else if (w_gnt1)
        r_prio1 <= 1'b0;
      unique case (r_state)
        BOOT_ID: begin
          r_err[0] <= w_id_bad;
          r_state  <= BOOT_TS;
        end
        BOOT_TS: begin
          r_err[1] <= w_ts_bad;
          r_done   <= 1'b1;
          r_pass   <= ~r_err[0] & ~w_ts_bad;
          r_state  <= ARB;
        end
        default: r_state <= ARB;
      endcase
    end
  end

  assign m0_waitrequest   = ~w_gnt0;
  assign m1_waitrequest   = ~w_gnt1;
  // A response due in a reset cycle is in flight and gets dropped.
  assign m0_readdatavalid = r_rdv0 & ~reset;
  assign m1_readdatavalid = r_rdv1 & ~reset;
  assign m0_readdata      = r_rd0;
  assign m1_readdata      = r_rd1;
  assign check_done       = r_done;
  assign check_pass       = r_pass;
  assign check_err_mask   = r_err;

endmodule

// File: tb/tb_nios_mtl_sysid_arbiter.sv
// tb_nios_mtl_sysid_arbiter: random requester traffic against a queue
// based reference model with a separate response monitor.
module tb_nios_mtl_sysid_arbiter;

  localparam logic [31:0] EID = 32'd0;
  localparam logic [31:0] ETS = 32'd1459350768;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        m0_address = 1'b0;
  logic        m0_read = 1'b0;
  logic        m0_waitrequest;
  logic [31:0] m0_readdata;
  logic        m0_readdatavalid;
  logic        m1_address = 1'b0;
  logic        m1_read = 1'b0;
  logic        m1_waitrequest;
  logic [31:0] m1_readdata;
  logic        m1_readdatavalid;
  logic        s_address;
  logic [31:0] s_readdata;
  logic        check_done;
  logic        check_pass;
  logic [1:0]  check_err_mask;

  logic [31:0] id_val = EID;
  logic [31:0] ts_val = ETS;

  nios_mtl_sysid_arbiter #(
    .EXPECTED_ID(EID),
    .EXPECTED_TS(ETS)
  ) dut (
    .clock(clock),
    .reset(reset),
    .m0_address(m0_address),
    .m0_read(m0_read),
    .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata),
    .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address),
    .m1_read(m1_read),
    .m1_waitrequest(m1_waitrequest),
    .m1_readdata(m1_readdata),
    .m1_readdatavalid(m1_readdatavalid),
    .s_address(s_address),
    .s_readdata(s_readdata),
    .check_done(check_done),
    .check_pass(check_pass),
    .check_err_mask(check_err_mask)
  );

  always #5 clock = ~clock;

  assign s_readdata = s_address ? ts_val : id_val;

  typedef struct {
    int          c;
    logic [31:0] d;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic rst_q = 1'b1;

  always @(posedge clock) begin
    cyc   <= cyc + 1;
    rst_q <= reset;
  end

  task automatic chk(input string n, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h cycle %0d",
               n, act, exp, cyc);
    end
  endtask

  // Response monitor
  logic [31:0] r0 = 32'd0;
  logic [31:0] r1 = 32'd0;

  always @(negedge clock) begin
    exp_t e;
    if (rst_q) begin
      r0 = 32'd0;
      r1 = 32'd0;
    end
    if (m0_readdatavalid) begin
      if (q0.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rdv0_unexpected: got 1 expected 0 cycle %0d", cyc);
      end else begin
        e = q0.pop_front();
        chk("rd0_data", m0_readdata, e.d);
        chk("rd0_latency", cyc, e.c + 1);
        r0 = e.d;
      end
    end else begin
      if (q0.size() != 0 && q0[0].c < cyc) begin
        total++;
        bad++;
        $display("FAIL rdv0_missing: got 0 expected 1 cycle %0d", cyc);
        void'(q0.pop_front());
      end
      if (!reset)
        chk("rd0_hold", m0_readdata, r0);
    end
    if (m1_readdatavalid) begin
      if (q1.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rdv1_unexpected: got 1 expected 0 cycle %0d", cyc);
      end else begin
        e = q1.pop_front();
        chk("rd1_data", m1_readdata, e.d);
        chk("rd1_latency", cyc, e.c + 1);
        r1 = e.d;
      end
    end else begin
      if (q1.size() != 0 && q1[0].c < cyc) begin
        total++;
        bad++;
        $display("FAIL rdv1_missing: got 0 expected 1 cycle %0d", cyc);
        void'(q1.pop_front());
      end
      if (!reset)
        chk("rd1_hold", m1_readdata, r1);
    end
  end

  // Requester state and reference model
  bit p0 = 1'b0;
  bit p1 = 1'b0;
  bit a0 = 1'b0;
  bit a1 = 1'b0;
  int pr0 = 50;
  int pr1 = 50;
  int boot_left = 2;
  bit last1 = 1'b1;
  bit prev_rst = 1'b1;

  task automatic step(input bit rst);
    bit       g0;
    bit       g1;
    bit       arb;
    bit       e_pass;
    bit [1:0] e_mask;
    @(posedge clock);
    #1;
    reset      = rst;
    m0_read    = p0;
    m0_address = a0;
    m1_read    = p1;
    m1_address = a1;
    if (rst) begin
      q0.delete();
      q1.delete();
    end
    arb = !rst && boot_left == 0;
    g0 = 1'b0;
    g1 = 1'b0;
    if (arb) begin
      if (p0 && p1) begin
        g0 = last1;
        g1 = !last1;
      end else begin
        g0 = p0;
        g1 = p1;
      end
    end
    e_mask = {ts_val != ETS, id_val != EID};
    e_pass = (e_mask == 2'b00);
    @(negedge clock);
    chk("wait0", m0_waitrequest, !g0);
    chk("wait1", m1_waitrequest, !g1);
    if (arb) begin
      chk("s_addr", s_address, g0 ? a0 : (g1 ? a1 : 1'b0));
      chk("done", check_done, 1'b1);
      chk("pass", check_pass, e_pass);
      chk("mask", check_err_mask, e_mask);
    end else if (!rst || prev_rst) begin
      chk("done_boot", check_done, 1'b0);
      chk("pass_boot", check_pass, 1'b0);
      if (rst || boot_left == 2)
        chk("mask_boot", check_err_mask, 2'b00);
    end
    #1;
    if (g0) begin
      q0.push_back('{cyc, a0 ? ts_val : id_val});
      last1 = 1'b0;
      p0 = 1'b0;
    end
    if (g1) begin
      q1.push_back('{cyc, a1 ? ts_val : id_val});
      last1 = 1'b1;
      p1 = 1'b0;
    end
    if (!rst && boot_left > 0)
      boot_left--;
    if (rst) begin
      boot_left = 2;
      last1 = 1'b1;
    end
    prev_rst = rst;
    if (!p0) begin
      p0 = $urandom_range(99) < pr0;
      a0 = 1'($urandom_range(1));
    end
    if (!p1) begin
      p1 = $urandom_range(99) < pr1;
      a1 = 1'($urandom_range(1));
    end
  endtask

  initial begin
    // Requests raised during reset/boot, then continuous dual traffic.
    p0 = 1'b1;
    a0 = 1'b1;
    p1 = 1'b1;
    a1 = 1'b0;
    pr0 = 100;
    pr1 = 100;
    repeat (2) step(1'b1);
    repeat (10) step(1'b0);
    pr0 = 50;
    pr1 = 50;
    repeat (200) step(1'b0);
    // Mostly lone m0 traffic.
    pr1 = 0;
    pr0 = 70;
    repeat (40) step(1'b0);
    // Reset right after an m1 grant.
    pr0 = 0;
    pr1 = 0;
    repeat (4) step(1'b0);
    p1 = 1'b1;
    a1 = 1'b1;
    step(1'b0);
    step(1'b1);
    step(1'b1);
    repeat (6) step(1'b0);
    // Boot check with every combination of good/bad slave words.
    for (int c = 0; c < 4; c++) begin
      pr0 = 60;
      pr1 = 60;
      step(1'b1);
      id_val = c[0] ? 32'h5 : EID;
      ts_val = c[1] ? (ETS ^ 32'h100) : ETS;
      step(1'b1);
      repeat (150) step(1'b0);
    end
    pr0 = 0;
    pr1 = 0;
    repeat (5) step(1'b0);
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
